// File: rtl/bht_access_scheduler.sv
// bht_access_scheduler: single-port 2-bit counter table shared by lookups and queued branch updates
module bht_access_scheduler #(
    parameter int IDX_W      = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int AGE_MAX    = 8,
    parameter int MISS_W     = 16
) (
    input  logic                              CLOCK,
    input  logic                              INIT,
    input  logic                              LK_VALID,
    input  logic [IDX_W-1:0]                  LK_ADDR,
    output logic                              LK_READY,
    output logic                              PREDICTION,
    output logic                              PRED_VALID,
    input  logic                              UPD_VALID,
    input  logic [IDX_W-1:0]                  UPD_ADDR,
    input  logic                              UPD_OUTCOME,
    input  logic                              UPD_PRED,
    output logic                              UPD_READY,
    output logic [MISS_W-1:0]                 MISSES,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   PENDING
);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int AGE_W   = $clog2(AGE_MAX + 1);
    localparam int ENTRIES = 1 << IDX_W;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t           state;
    logic [IDX_W-1:0] clear_idx;
    logic [1:0]       table_mem [ENTRIES];
    logic [IDX_W-1:0] fifo_addr [FIFO_DEPTH];
    logic             fifo_taken [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [AGE_W-1:0] age;
    logic             run, forced, lk_accept, drain, enq;
    logic [IDX_W-1:0] head_addr;
    logic [1:0]       head_cnt, next_cnt;

    assign run       = state == RUN;
    // A full FIFO or a head that has waited too long steals the cycle from lookups
    assign forced    = run && (PENDING == CNT_W'(FIFO_DEPTH) || (PENDING != '0 && age >= AGE_W'(AGE_MAX)));
    assign LK_READY  = run && !forced;
    assign lk_accept = LK_VALID && LK_READY;
    assign drain     = forced || (run && !LK_VALID && PENDING != '0);
    assign UPD_READY = run && PENDING < CNT_W'(FIFO_DEPTH);
    assign enq       = UPD_VALID && UPD_READY;
    assign head_addr = fifo_addr[rd_ptr];
    assign head_cnt  = table_mem[head_addr];
    assign next_cnt  = fifo_taken[rd_ptr] ? (head_cnt == 2'b11 ? 2'b11 : head_cnt + 2'd1)
                                          : (head_cnt == 2'b00 ? 2'b00 : head_cnt - 2'd1);

    always_ff @(posedge CLOCK) begin
        if (INIT && state == CLEAR)
            table_mem[clear_idx] <= 2'b01;
        else if (INIT && drain)
            table_mem[head_addr] <= next_cnt;
    end

    always_ff @(posedge CLOCK) begin
        if (INIT && enq) begin
            fifo_addr[wr_ptr]  <= UPD_ADDR;
            fifo_taken[wr_ptr] <= UPD_OUTCOME;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!INIT) begin
            state      <= CLEAR;
            clear_idx  <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            PENDING    <= '0;
            age        <= '0;
            MISSES     <= '0;
            PREDICTION <= 1'b0;
            PRED_VALID <= 1'b0;
        end else begin
            PRED_VALID <= lk_accept;
            if (lk_accept)
                PREDICTION <= table_mem[LK_ADDR][1];
            if (state == CLEAR) begin
                clear_idx <= clear_idx + 1'b1;
                if (clear_idx == '1)
                    state <= RUN;
            end
            if (drain)
                rd_ptr <= rd_ptr + 1'b1;
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (UPD_OUTCOME != UPD_PRED && MISSES != '1)
                    MISSES <= MISSES + 1'b1;
            end
            PENDING <= PENDING + CNT_W'(enq) - CNT_W'(drain);
            // Age tracks how long the current head has been waiting
            age <= (drain || PENDING == '0) ? '0 : (age >= AGE_W'(AGE_MAX) ? age : age + 1'b1);
        end
    end
endmodule

// File: tb/tb_bht_access_scheduler.sv
// tb_bht_access_scheduler: directed stimulus with hand-computed expectations for bht_access_scheduler
module tb_bht_access_scheduler;
    logic        CLOCK, INIT, LK_VALID, LK_READY, PREDICTION, PRED_VALID;
    logic        UPD_VALID, UPD_OUTCOME, UPD_PRED, UPD_READY;
    logic [2:0]  LK_ADDR, UPD_ADDR, PENDING;
    logic [15:0] MISSES;
    int          n_cmp = 0;
    int          n_err = 0;

    bht_access_scheduler dut (
        .CLOCK(CLOCK), .INIT(INIT), .LK_VALID(LK_VALID), .LK_ADDR(LK_ADDR), .LK_READY(LK_READY),
        .PREDICTION(PREDICTION), .PRED_VALID(PRED_VALID), .UPD_VALID(UPD_VALID), .UPD_ADDR(UPD_ADDR),
        .UPD_OUTCOME(UPD_OUTCOME), .UPD_PRED(UPD_PRED), .UPD_READY(UPD_READY), .MISSES(MISSES),
        .PENDING(PENDING)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic upd(input logic [2:0] a, input logic o, input logic p);
        UPD_VALID = 1'b1; UPD_ADDR = a; UPD_OUTCOME = o; UPD_PRED = p;
        tick();
        UPD_VALID = 1'b0;
        tick();
        chk("upd_drained", PENDING, 0);
    endtask

    task automatic look(input logic [2:0] a, input logic exp);
        LK_VALID = 1'b1; LK_ADDR = a;
        tick();
        chk("look_valid", PRED_VALID, 1);
        chk("look_pred", PREDICTION, exp);
        LK_VALID = 1'b0;
    endtask

    task automatic clear_and_sweep();
        for (int i = 0; i < 8; i++) begin
            chk("clear_lk_ready", LK_READY, 0);
            chk("clear_upd_ready", UPD_READY, 0);
            tick();
        end
        chk("run_lk_ready", LK_READY, 1);
        for (int i = 0; i < 8; i++) look(3'(i), 1'b0);
        tick();
        chk("idle_pred_valid", PRED_VALID, 0);
    endtask

    initial begin
        INIT = 1'b0; LK_VALID = 1'b0; LK_ADDR = '0;
        UPD_VALID = 1'b0; UPD_ADDR = '0; UPD_OUTCOME = 1'b0; UPD_PRED = 1'b0;
        tick();
        tick();
        chk("rst_pending", PENDING, 0);
        chk("rst_misses", MISSES, 0);
        chk("rst_pred_valid", PRED_VALID, 0);
        chk("rst_prediction", PREDICTION, 0);
        chk("rst_lk_ready", LK_READY, 0);
        INIT = 1'b1;
        clear_and_sweep();

        // two taken updates to index 5: 01 -> 10 -> 11
        UPD_VALID = 1'b1; UPD_ADDR = 3'd5; UPD_OUTCOME = 1'b1; UPD_PRED = 1'b1;
        chk("upd_ready", UPD_READY, 1);
        tick();
        chk("pend_1a", PENDING, 1);
        tick();
        chk("pend_1b", PENDING, 1);
        UPD_VALID = 1'b0;
        tick();
        chk("pend_0", PENDING, 0);
        look(3'd5, 1'b1);
        upd(3'd5, 1'b1, 1'b1);
        look(3'd5, 1'b1);
        upd(3'd5, 1'b0, 1'b0);
        look(3'd5, 1'b1);
        upd(3'd5, 1'b0, 1'b0);
        look(3'd5, 1'b0);
        upd(3'd5, 1'b0, 1'b0);
        upd(3'd5, 1'b0, 1'b0);
        upd(3'd5, 1'b1, 1'b1);
        look(3'd5, 1'b0);
        chk("no_misses", MISSES, 0);

        // lookups saturate the port; a single update waits for the age limit
        LK_VALID = 1'b1; LK_ADDR = 3'd0;
        UPD_VALID = 1'b1; UPD_ADDR = 3'd2; UPD_OUTCOME = 1'b1; UPD_PRED = 1'b1;
        tick();
        UPD_VALID = 1'b0;
        chk("age_pend_start", PENDING, 1);
        for (int k = 1; k <= 8; k++) begin
            chk("age_lk_ready", LK_READY, 1);
            tick();
            chk("age_pred_valid", PRED_VALID, 1);
            chk("age_pending", PENDING, 1);
        end
        chk("age_forced_lk_ready", LK_READY, 0);
        tick();
        chk("age_drained", PENDING, 0);
        chk("age_no_pred", PRED_VALID, 0);
        chk("age_lk_back", LK_READY, 1);
        LK_ADDR = 3'd2;
        tick();
        chk("age_pred_valid_back", PRED_VALID, 1);
        chk("age_idx2_taken", PREDICTION, 1);

        // fill the FIFO under continuous lookups: three mispredicts and one correct
        UPD_VALID = 1'b1; UPD_ADDR = 3'd3; UPD_OUTCOME = 1'b1; UPD_PRED = 1'b0;
        tick();
        chk("fill_1", PENDING, 1);
        tick();
        chk("fill_2", PENDING, 2);
        tick();
        chk("fill_3", PENDING, 3);
        UPD_OUTCOME = 1'b0;
        tick();
        chk("fill_4", PENDING, 4);
        chk("full_upd_ready", UPD_READY, 0);
        chk("full_lk_ready", LK_READY, 0);
        chk("fill_misses", MISSES, 3);
        UPD_OUTCOME = 1'b1;
        tick();
        chk("full_drain_pend", PENDING, 3);
        chk("full_drain_no_pred", PRED_VALID, 0);
        chk("full_upd_ready_back", UPD_READY, 1);
        chk("full_refused_no_miss", MISSES, 3);
        UPD_VALID = 1'b0;

        // reset with pending work discards it and re-clears the table
        INIT = 1'b0;
        tick();
        chk("mid_rst_pending", PENDING, 0);
        chk("mid_rst_misses", MISSES, 0);
        chk("mid_rst_pred_valid", PRED_VALID, 0);
        INIT = 1'b1; LK_VALID = 1'b0;
        clear_and_sweep();

        // mispredict counter saturation
        UPD_VALID = 1'b1; UPD_ADDR = 3'd1; UPD_OUTCOME = 1'b1; UPD_PRED = 1'b0;
        for (int k = 0; k < 65534; k++) tick();
        chk("miss_fffe", MISSES, 16'hFFFE);
        chk("miss_stream_pending", PENDING, 1);
        tick();
        chk("miss_ffff", MISSES, 16'hFFFF);
        tick();
        tick();
        chk("miss_hold", MISSES, 16'hFFFF);
        UPD_VALID = 1'b0;
        tick();
        chk("miss_end_pending", PENDING, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/bht_access_scheduler.md
Name: bht_access_scheduler

Overview:
- Owns a single-port table of 2-bit saturating branch counters and schedules every access to it.
- Two requesters share the table: the fetch-side lookup port (read, one per cycle) and the execute-side resolved-branch update port (write, queued in a small FIFO).
- Also sequences table clearing after reset and keeps the saturating mispredict count.

Parameters:
IDX_W, 3, table index width; table has 2**IDX_W entries
FIFO_DEPTH, 4, pending-update FIFO entries (power of 2, >=2)
AGE_MAX, 8, max cycles the FIFO head may wait before a forced drain
MISS_W, 16, mispredict counter width

Ports:
CLOCK  in  1  clock, all state on posedge
INIT  in  1  synchronous reset, active-low
LK_VALID  in  1  lookup request this cycle
LK_ADDR  in  IDX_W  lookup index
LK_READY  out  1  lookup accepted this cycle when LK_VALID & LK_READY
PREDICTION  out  1  registered prediction (counter MSB) for last accepted lookup
PRED_VALID  out  1  PREDICTION valid, one-cycle pulse
UPD_VALID  in  1  resolved branch update request
UPD_ADDR  in  IDX_W  index of resolved branch
UPD_OUTCOME  in  1  actual outcome, 1 = taken
UPD_PRED  in  1  prediction originally issued for this branch
UPD_READY  out  1  FIFO can accept; enqueue when UPD_VALID & UPD_READY
MISSES  out  MISS_W  saturating mispredict count
PENDING  out  clog2(FIFO_DEPTH+1)  FIFO occupancy

Behaviour:
- INIT low at a posedge: state<=CLEAR, clear_idx<=0, FIFO empty, age<=0, MISSES<=0, PREDICTION<=0, PRED_VALID<=0. INIT low mid-operation discards all pending updates and any in-flight prediction.
- FSM CLEAR:
  - Writes 2'b01 (weakly not-taken) to entry clear_idx each cycle and increments clear_idx.
  - After writing entry 2**IDX_W-1, goes to RUN. CLEAR lasts exactly 2**IDX_W cycles after INIT returns high.
  - LK_READY=0 and UPD_READY=0 throughout.
- FSM RUN: exactly one table action per cycle, chosen in priority order:
  1. Forced drain: (PENDING==FIFO_DEPTH) or (PENDING!=0 and age>=AGE_MAX). Head entry written, LK_READY=0.
  2. Lookup: LK_VALID=1. LK_READY=1, table read.
  3. Opportunistic drain: PENDING!=0.
  4. Idle.
- LK_READY is combinational: 1 in RUN unless a forced drain is selected. It does not depend on LK_VALID.
- Lookup latency 1: accepted at edge t gives PREDICTION=entry[LK_ADDR][1] and PRED_VALID=1 after edge t. PRED_VALID=0 after any cycle without an accepted lookup; PREDICTION then holds its last value.
- Lookups read the table as stored. No forwarding from the FIFO; stale reads of pending indices are permitted.
- Drain write: entry<=sat(entry + (outcome ? +1 : -1)), saturating at 2'b11 and 2'b00.
- UPD_READY = (state==RUN) & (PENDING<FIFO_DEPTH). There is no pass-through when full, even if a drain happens the same cycle.
- Simultaneous enqueue and dequeue: PENDING unchanged, FIFO order preserved. Read/write pointers wrap modulo FIFO_DEPTH.
- Age counter:
  - Reset to 0 on any dequeue, and held at 0 while the FIFO is empty.
  - Otherwise increments each cycle, saturating at AGE_MAX.
  - Counts from when an entry becomes head.
- MISSES updates at enqueue time, not at drain: +1 when UPD_OUTCOME!=UPD_PRED, saturating at all-ones. Updates discarded by INIT still count if enqueued before reset; the reset itself zeroes MISSES.
- Same-index updates drain in FIFO order, so repeated updates to one index are cumulative.

Test Plan:
- Reset with INIT low 2 cycles, then high -> LK_READY=0 for exactly 8 cycles, then 1. A lookup of every index 0..7 returns PREDICTION=0 with PRED_VALID one cycle after each accept.
- No lookups; enqueue 2 taken updates to index 5 -> PENDING goes 1 then back to 0 within 3 cycles. Lookup index 5 then gives PREDICTION=1 (counter 11). A third taken update leaves it saturated at 11.
- LK_VALID held high continuously; enqueue 1 update -> it drains only when age reaches 8. LK_READY=0 for exactly that one cycle, and PRED_VALID=0 on the following cycle.
- LK_VALID held high; enqueue 4 updates back-to-back -> UPD_READY=0 once PENDING=4. Next cycle is a forced drain with LK_READY=0, then PENDING=3 and UPD_READY=1.
- Enqueue 3 updates with UPD_OUTCOME!=UPD_PRED and 1 with them equal -> MISSES=3. Preload MISSES near 16'hFFFF via repeated mispredicts -> holds at 16'hFFFF.
- Pull INIT low with PENDING=3 during RUN -> PENDING=0, MISSES=0 and PRED_VALID=0 next cycle, CLEAR re-entered. Table returns to all 01 (all lookups predict 0).
